// File: rtl/io_bridge.sv
// CPU data-port bridge: memory accesses pass straight through, IO-window accesses
// run a strobe/ack handshake that stalls the CPU. Optional macro: IO_TIMEOUT_EN.
module io_bridge #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int WIN_BITS  = 2,
  parameter int IO_PREFIX = 3,
  parameter int NUM_CH    = 4,
  parameter int CH_LSB    = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     we,
  input  logic                     re,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     mem_we,
  output logic                     stall,
  output logic [NUM_CH-1:0]        io_sel,
  output logic                     io_we,
  output logic                     io_re,
  output logic [CH_LSB-1:0]        io_addr,
  output logic [DATA_W-1:0]        io_wdata,
  input  logic [NUM_CH*DATA_W-1:0] io_rdata,
  input  logic [NUM_CH-1:0]        io_ack,
  output logic                     err
);

  localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [CH_BITS-1:0]  ch_q, ch_d;
  logic [CH_LSB-1:0]   off_q, off_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   cap_q, cap_d;
  logic                write_q, write_d;
  logic                err_q, err_d;

  logic                io_hit;
  logic                req;
  logic                ch_bad;
  logic                ack_hit;
  logic [CH_BITS-1:0]  addr_ch;
  logic [DATA_W-1:0]   ch_rdata;
  logic                unused_ok;

  assign io_hit   = (addr[ADDR_W-1 -: WIN_BITS] == WIN_BITS'(IO_PREFIX));
  assign req      = we | re;
  assign addr_ch  = addr[CH_LSB +: CH_BITS];
  assign ch_bad   = ({1'b0, addr_ch} >= (CH_BITS+1)'(NUM_CH));
  assign io_addr  = off_q;
  assign io_wdata = wdata_q;

`ifdef IO_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign unused_ok = ^addr;
`else
  assign unused_ok = ^{addr, (TIMEOUT > 0)};
`endif

  // Only the latched channel's ack and read slice matter; other channels are ignored.
  always_comb begin
    ack_hit  = 1'b0;
    ch_rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == CH_BITS'(c)) begin
        ack_hit  = io_ack[c];
        ch_rdata = io_rdata[c*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    cap_d   = cap_q;
    write_d = write_q;
    err_d   = err_q;
`ifdef IO_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (io_hit && req) begin
          ch_d    = addr_ch;
          off_d   = addr[CH_LSB-1:0];
          wdata_d = wdata;
          write_d = we;
          cap_d   = '0;
          err_d   = ch_bad;
          state_d = ch_bad ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (ack_hit) begin
          if (!write_q) cap_d = ch_rdata;
          state_d = DONE;
        end else begin
          state_d = WAIT;
`ifdef IO_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT: begin
        if (ack_hit) begin
          if (!write_q) cap_d = ch_rdata;
          state_d = DONE;
        end
`ifdef IO_TIMEOUT_EN
        // Expiry on the TIMEOUT-th WAIT cycle; a same-cycle ack above takes priority.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          cap_d   = '1;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata  = '0;
    mem_we = 1'b0;
    stall  = 1'b0;
    io_sel = '0;
    io_we  = 1'b0;
    io_re  = 1'b0;
    err    = 1'b0;
    if (state_q != DONE && !io_hit) begin
      rdata  = mem_rdata;
      mem_we = we;
    end
    case (state_q)
      IDLE:  stall = io_hit & req;
      ISSUE: begin
        stall = 1'b1;
        io_we = write_q;
        io_re = !write_q;
        for (int c = 0; c < NUM_CH; c++) io_sel[c] = (ch_q == CH_BITS'(c));
      end
      WAIT: begin
        stall = 1'b1;
        for (int c = 0; c < NUM_CH; c++) io_sel[c] = (ch_q == CH_BITS'(c));
      end
      DONE: begin
        rdata = cap_q;
        err   = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      cap_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef IO_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      cap_q   <= cap_d;
      write_q <= write_d;
      err_q   <= err_d;
`ifdef IO_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule
